// File: rtl/iob_cache_axi_pkg.sv
// Shared definitions for the cache AXI RAM responder: response codes and FSM states.
package iob_cache_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

endpackage

// File: rtl/iob_cache_axi_ram_2p.sv
// Simple dual-port RAM: byte-enabled write port, synchronous read port, read-before-write.
module iob_cache_axi_ram_2p #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk_i,
  input  logic                w_en_i,
  input  logic [DATA_W/8-1:0] w_strb_i,
  input  logic [ADDR_W-1:0]   w_addr_i,
  input  logic [DATA_W-1:0]   w_data_i,
  input  logic                r_en_i,
  input  logic [ADDR_W-1:0]   r_addr_i,
  output logic [DATA_W-1:0]   r_data_o
);

  localparam int unsigned STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] r_data_q;

  always_ff @(posedge clk_i) begin
    if (w_en_i) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (w_strb_i[i]) mem_q[w_addr_i][i*8 +: 8] <= w_data_i[i*8 +: 8];
      end
    end
  end

  // Output holds between reads so a stalled beat keeps its data.
  always_ff @(posedge clk_i) begin
    if (r_en_i) r_data_q <= mem_q[r_addr_i];
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/iob_cache_axi_ram_responder.sv
// AXI4 subordinate memory model: independent read and write burst FSMs over a 2-port RAM.
module iob_cache_axi_ram_responder
  import iob_cache_axi_pkg::*;
#(
  parameter int AXI_ID_W   = 1,
  parameter int AXI_ID     = 0,
  parameter int AXI_LEN_W  = 8,
  parameter int AXI_ADDR_W = 24,
  parameter int AXI_DATA_W = 32,
  parameter int MEM_ADDR_W = 12
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  output logic [AXI_DATA_W-1:0]   axi_rdata_o,
  output logic [AXI_ID_W-1:0]     axi_rid_o,
  output logic [1:0]              axi_rresp_o,
  output logic                    axi_rlast_o,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
  input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
  input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
  input  logic                    axi_wlast_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  output logic [AXI_ID_W-1:0]     axi_bid_o,
  output logic [1:0]              axi_bresp_o,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i
);

  localparam int NB_W = $clog2(AXI_DATA_W / 8);

  rd_state_e             rd_state_q, rd_state_d;
  logic [MEM_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [AXI_LEN_W-1:0]  rd_len_q, rd_len_d;
  logic [AXI_LEN_W-1:0]  rd_cnt_q, rd_cnt_d;

  wr_state_e             wr_state_q, wr_state_d;
  logic [MEM_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [AXI_LEN_W-1:0]  wr_len_q, wr_len_d;
  logic [AXI_LEN_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic                  wr_err_q, wr_err_d;

  logic ram_ren, ram_wen;
  logic rd_last, wr_last;

  // Upper address bits alias and byte-offset bits are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{axi_araddr_i, axi_awaddr_i};

  assign rd_last = (rd_cnt_q == rd_len_q);
  assign wr_last = (wr_cnt_q == wr_len_q);

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      rd_state_q <= R_IDLE;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      wr_state_q <= W_IDLE;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_addr_q  <= rd_addr_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_state_q <= wr_state_d;
      wr_addr_q  <= wr_addr_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    rd_addr_d  = rd_addr_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    unique case (rd_state_q)
      R_IDLE: begin
        if (axi_arvalid_i) begin
          rd_addr_d  = axi_araddr_i[NB_W +: MEM_ADDR_W];
          rd_len_d   = axi_arlen_i;
          rd_cnt_d   = '0;
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: rd_state_d = R_DATA;
      R_DATA: begin
        if (axi_rready_i) begin
          if (rd_last) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_addr_d  = rd_addr_q + MEM_ADDR_W'(1);
            rd_cnt_d   = rd_cnt_q + AXI_LEN_W'(1);
            rd_state_d = R_FETCH;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d = wr_state_q;
    wr_addr_d  = wr_addr_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_err_d   = wr_err_q;
    unique case (wr_state_q)
      W_IDLE: begin
        if (axi_awvalid_i) begin
          wr_addr_d  = axi_awaddr_i[NB_W +: MEM_ADDR_W];
          wr_len_d   = axi_awlen_i;
          wr_cnt_d   = '0;
          wr_err_d   = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (axi_wvalid_i) begin
          // The counter ends the burst; a disagreeing wlast only flags an error.
          wr_err_d  = wr_err_q | (axi_wlast_i != wr_last);
          wr_addr_d = wr_addr_q + MEM_ADDR_W'(1);
          wr_cnt_d  = wr_cnt_q + AXI_LEN_W'(1);
          if (wr_last) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi_bready_i) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    axi_arready_o = (rd_state_q == R_IDLE) && !arst_i;
    axi_rvalid_o  = (rd_state_q == R_DATA);
    axi_rlast_o   = axi_rvalid_o && rd_last;
    ram_ren       = (rd_state_q == R_FETCH);
    axi_awready_o = (wr_state_q == W_IDLE) && !arst_i;
    axi_wready_o  = (wr_state_q == W_DATA);
    ram_wen       = axi_wready_o && axi_wvalid_i;
    axi_bvalid_o  = (wr_state_q == W_RESP);
    axi_bresp_o   = (axi_bvalid_o && wr_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  end

  assign axi_rid_o   = AXI_ID_W'(AXI_ID);
  assign axi_bid_o   = AXI_ID_W'(AXI_ID);
  assign axi_rresp_o = AXI_RESP_OKAY;

  iob_cache_axi_ram_2p #(
    .DATA_W(AXI_DATA_W),
    .ADDR_W(MEM_ADDR_W)
  ) u_ram (
    .clk_i   (clk_i),
    .w_en_i  (ram_wen),
    .w_strb_i(axi_wstrb_i),
    .w_addr_i(wr_addr_q),
    .w_data_i(axi_wdata_i),
    .r_en_i  (ram_ren),
    .r_addr_i(rd_addr_q),
    .r_data_o(axi_rdata_o)
  );

endmodule
